intersection_controller: RTL and testbench
==========================================

INTERSECTION_CONTROLLER -- requirements
Module: intersection_controller

Interface
REQ-001 The block SHALL take parameter T_MAIN_GREEN, default 8, minimum main-road green duration in clk cycles.
REQ-002 The block SHALL take parameter T_SIDE_GREEN, default 5, side-road green duration in clk cycles.
REQ-003 The block SHALL take parameter T_YELLOW, default 2, yellow duration in clk cycles for either road.
REQ-004 The block SHALL take parameter T_ALLRED, default 1, all-red clearance duration in clk cycles.
REQ-005 The block SHALL take parameter TW, default 8, timer width in bits; each T_* parameter is in the range 1..2^TW-1.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port side_req, input, 1 bit, side-road vehicle sensor, level or pulse.
REQ-009 The block SHALL have port ped_req, input, 1 bit, pedestrian push-button; the port exists only with PED_REQ_EN.
REQ-010 The block SHALL have port main_light, output, 3 bits, main-road head: RED=100, GREEN=010, YELLOW=001.
REQ-011 The block SHALL have port side_light, output, 3 bits, side-road head, same encoding as main_light.
REQ-012 The block SHALL have port ped_walk, output, 1 bit, walk signal across the main road; the port exists only with PED_REQ_EN.

Function
REQ-013 The block SHALL implement a Moore FSM with states MAIN_G, MAIN_Y, CLR_MS, SIDE_G, SIDE_Y, CLR_SM, and all outputs SHALL be decoded from the state register only.
REQ-014 The outputs SHALL decode as follows: MAIN_G gives main GREEN/side RED; MAIN_Y gives main YELLOW/side RED; CLR_MS and CLR_SM give both RED; SIDE_G gives main RED/side GREEN; SIDE_Y gives main RED/side YELLOW.
REQ-015 On entry to each state, the timer SHALL load duration-1 and decrement by 1 per cycle, saturating at 0.
REQ-016 Because of REQ-015, each timed state SHALL last exactly its duration in cycles.
REQ-017 MAIN_Y, CLR_MS, SIDE_G, SIDE_Y and CLR_SM SHALL advance unconditionally when the timer is 0, in the order MAIN_Y->CLR_MS->SIDE_G->SIDE_Y->CLR_SM->MAIN_G.
REQ-018 MAIN_G SHALL advance to MAIN_Y only when the timer is 0 and (pending or side_req) is 1; otherwise it SHALL hold with the timer at 0, with no maximum dwell.
REQ-019 The pending flag SHALL set on any cycle with side_req=1 in any state except SIDE_G, and SHALL clear on the transition into SIDE_G.
REQ-020 A side_req asserted on the same cycle as the CLR_MS->SIDE_G transition SHALL be consumed: pending ends 0, because clear wins.
REQ-021 A side_req asserted during SIDE_G SHALL be ignored; a side_req asserted during SIDE_Y or CLR_SM SHALL set pending and SHALL cause the next cycle after the minimum main green.
REQ-022 Any illegal state encoding SHALL go to MAIN_G with the timer reloaded on the next edge.
REQ-023 main_light and side_light SHALL never both be non-RED in any cycle.

Reset
REQ-024 While rst=1 at a clk edge, state SHALL become MAIN_G, the timer SHALL become T_MAIN_GREEN-1, pending SHALL become 0, and ped_walk SHALL become 0.
REQ-025 After reset, outputs SHALL be main_light=010 and side_light=100.
REQ-026 Reset asserted in any state, mid-phase, SHALL take effect at the next edge with no yellow or clearance sequence.

Configuration
REQ-027 When macro PED_REQ_EN is defined, the ped_req and ped_walk ports SHALL exist, and ped_req SHALL set pending by the same rules as side_req.
REQ-028 When PED_REQ_EN is defined, ped_walk SHALL be 1 exactly while in SIDE_G and 0 otherwise.
REQ-029 When PED_REQ_EN is not defined, the ped_req and ped_walk ports and their logic SHALL be absent, with behaviour otherwise identical.

Verification (default parameters; cycle 0 = first cycle with rst=0)
REQ-030 Scenario: side_req held 1 from cycle 0 -> MAIN_G in cycles 0-7, MAIN_Y 8-9, CLR_MS 10, SIDE_G 11-15, SIDE_Y 16-17, CLR_SM 18, MAIN_G from cycle 19.
REQ-031 Scenario: side_req=0 for 50 cycles -> main_light=010 and side_light=100 throughout.
REQ-032 Scenario: 1-cycle side_req pulse at cycle 3 -> main_light=001 at cycles 8-9 and side_light=010 at cycles 11-15.
REQ-033 Scenario: side_req pulse during SIDE_G only -> return to MAIN_G and hold there indefinitely; side_req pulse during SIDE_Y -> MAIN_Y starts exactly 8 cycles after re-entering MAIN_G.
REQ-034 Scenario: rst=1 for 1 cycle while in SIDE_Y -> main_light=010 and side_light=100 on the next cycle, and pending is cleared.
REQ-035 Scenario (PED_REQ_EN defined): ped_req pulse at cycle 0 -> ped_walk=1 at cycles 11-15 only; every cycle of every scenario is checked for REQ-023.

Source files
------------

// File: rtl/intersection_controller.sv
// Two-road intersection controller: Moore FSM cycling main green -> main yellow
// -> clearance -> side green -> side yellow -> clearance, with main green held
// until a side-road (or pedestrian) request is pending.
// Optional feature macro: PED_REQ_EN adds the ped_req input and ped_walk output.
module intersection_controller #(
  parameter int T_MAIN_GREEN = 8,
  parameter int T_SIDE_GREEN = 5,
  parameter int T_YELLOW     = 2,
  parameter int T_ALLRED     = 1,
  parameter int TW           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
`ifdef PED_REQ_EN
  input  logic       ped_req,
`endif
  output logic [2:0] main_light,
  output logic [2:0] side_light
`ifdef PED_REQ_EN
  ,
  output logic       ped_walk
`endif
);

  localparam logic [2:0] MAIN_G = 3'd0;
  localparam logic [2:0] MAIN_Y = 3'd1;
  localparam logic [2:0] CLR_MS = 3'd2;
  localparam logic [2:0] SIDE_G = 3'd3;
  localparam logic [2:0] SIDE_Y = 3'd4;
  localparam logic [2:0] CLR_SM = 3'd5;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  // Timer loads duration-1 so each phase lasts exactly its duration.
  localparam logic [TW-1:0] LD_MAIN = TW'(T_MAIN_GREEN - 1);
  localparam logic [TW-1:0] LD_SIDE = TW'(T_SIDE_GREEN - 1);
  localparam logic [TW-1:0] LD_YEL  = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] LD_CLR  = TW'(T_ALLRED - 1);

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          pending, pending_nxt;
  logic          req;

`ifdef PED_REQ_EN
  assign req = side_req | ped_req;
`else
  assign req = side_req;
`endif

  // Next-state and timer reload; main green waits for a request after its minimum.
  always_comb begin
    state_nxt = state;
    timer_nxt = (timer == '0) ? '0 : timer - TW'(1);
    case (state)
      MAIN_G: begin
        if (timer == '0 && (pending || req)) begin
          state_nxt = MAIN_Y;
          timer_nxt = LD_YEL;
        end
      end
      MAIN_Y: begin
        if (timer == '0) begin
          state_nxt = CLR_MS;
          timer_nxt = LD_CLR;
        end
      end
      CLR_MS: begin
        if (timer == '0) begin
          state_nxt = SIDE_G;
          timer_nxt = LD_SIDE;
        end
      end
      SIDE_G: begin
        if (timer == '0) begin
          state_nxt = SIDE_Y;
          timer_nxt = LD_YEL;
        end
      end
      SIDE_Y: begin
        if (timer == '0) begin
          state_nxt = CLR_SM;
          timer_nxt = LD_CLR;
        end
      end
      CLR_SM: begin
        if (timer == '0) begin
          state_nxt = MAIN_G;
          timer_nxt = LD_MAIN;
        end
      end
      default: begin
        state_nxt = MAIN_G;
        timer_nxt = LD_MAIN;
      end
    endcase
  end

  // Pending request latch: set outside side green, cleared on entry to side green (clear wins).
  always_comb begin
    pending_nxt = pending;
    if (req && state != SIDE_G) pending_nxt = 1'b1;
    if (state_nxt == SIDE_G && state != SIDE_G) pending_nxt = 1'b0;
  end

  // State, timer and pending registers with synchronous reset to main green.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MAIN_G;
      timer   <= LD_MAIN;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      pending <= pending_nxt;
    end
  end

  // Light decode from the state register only; illegal encodings show all red.
  always_comb begin
    main_light = RED;
    side_light = RED;
    case (state)
      MAIN_G: main_light = GREEN;
      MAIN_Y: main_light = YELLOW;
      SIDE_G: side_light = GREEN;
      SIDE_Y: side_light = YELLOW;
      default: begin
        main_light = RED;
        side_light = RED;
      end
    endcase
  end

`ifdef PED_REQ_EN
  // Walk signal across the main road is shown only during side green.
  always_comb begin
    ped_walk = (state == SIDE_G);
  end
`endif

endmodule

// File: tb/tb_intersection_controller.sv
// Bench for intersection_controller: phase/elapsed-time reference model,
// directed scenarios with literal expectations, then randomized traffic.
// Honours PED_REQ_EN when defined.
module tb_intersection_controller;

`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       side_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
`ifdef PED_REQ_EN
  logic       ped_req;
  logic       ped_walk;
`endif

  intersection_controller dut (
    .clk       (clk),
    .rst       (rst),
    .side_req  (side_req),
`ifdef PED_REQ_EN
    .ped_req   (ped_req),
    .ped_walk  (ped_walk),
`endif
    .main_light(main_light),
    .side_light(side_light)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: phase 0..5 = main green, main yellow, clear, side green,
  // side yellow, clear; el = cycles already spent in the phase.
  int dur [6] = '{8, 2, 1, 5, 2, 1};
  logic [2:0] mexp [6] = '{3'b010, 3'b001, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] sexp [6] = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b001, 3'b100};
  int ph = 0;
  int el = 0;
  bit pend = 1'b0;
  bit cur_rst, cur_req;

  task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit adv, np;
    if (cur_rst) begin
      ph = 0; el = 0; pend = 1'b0;
    end else begin
      adv = (el >= dur[ph] - 1) && (ph != 0 || pend || cur_req);
      np = pend;
      if (ph != 3 && cur_req) np = 1'b1;
      if (adv) begin
        ph = (ph + 1) % 6;
        el = 0;
        if (ph == 3) np = 1'b0;
      end else if (el < 100000) begin
        el++;
      end
      pend = np;
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  task automatic check_model();
    chk3("main_light", main_light, mexp[ph]);
    chk3("side_light", side_light, sexp[ph]);
    chk1("exclusive", !(main_light != 3'b100 && side_light != 3'b100), 1'b1);
`ifdef PED_REQ_EN
    chk1("ped_walk", ped_walk, ph == 3);
`endif
  endtask

  // Sit at the negedge of the next cycle and check the model.
  task automatic to_neg();
    @(negedge clk);
    check_model();
  endtask

  // Drive this cycle's inputs, then advance the model on the edge.
  task automatic drive(input bit r, input bit sr, input bit pr);
    rst = r;
    side_req = sr;
`ifdef PED_REQ_EN
    ped_req = pr;
`endif
    cur_rst = r;
    cur_req = sr | (pr & PED);
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    side_req = 1'b0;
`ifdef PED_REQ_EN
    ped_req = 1'b0;
`endif
    repeat (2) @(posedge clk);

    // side_req held from cycle 0: full cycle timing
    reset_dut();
    for (int c = 0; c < 25; c++) begin
      to_neg();
      if (c == 0) begin
        chk3("s030_rst_main", main_light, 3'b010);
        chk3("s030_rst_side", side_light, 3'b100);
      end
      if (c == 7)  chk3("s030_c7_main", main_light, 3'b010);
      if (c == 8)  chk3("s030_c8_main", main_light, 3'b001);
      if (c == 9)  chk3("s030_c9_main", main_light, 3'b001);
      if (c == 10) chk3("s030_c10_main", main_light, 3'b100);
      if (c == 10) chk3("s030_c10_side", side_light, 3'b100);
      if (c == 11) chk3("s030_c11_side", side_light, 3'b010);
      if (c == 15) chk3("s030_c15_side", side_light, 3'b010);
      if (c == 16) chk3("s030_c16_side", side_light, 3'b001);
      if (c == 18) chk3("s030_c18_side", side_light, 3'b100);
      if (c == 19) chk3("s030_c19_main", main_light, 3'b010);
      drive(1'b0, 1'b1, 1'b0);
    end

    // no requests for 50 cycles: main stays green
    reset_dut();
    for (int c = 0; c < 50; c++) begin
      to_neg();
      chk3("s031_main", main_light, 3'b010);
      chk3("s031_side", side_light, 3'b100);
      drive(1'b0, 1'b0, 1'b0);
    end

    // single pulse at cycle 3
    reset_dut();
    for (int c = 0; c < 20; c++) begin
      to_neg();
      if (c == 7)  chk3("s032_c7_main", main_light, 3'b010);
      if (c == 8)  chk3("s032_c8_main", main_light, 3'b001);
      if (c == 9)  chk3("s032_c9_main", main_light, 3'b001);
      if (c == 11) chk3("s032_c11_side", side_light, 3'b010);
      if (c == 15) chk3("s032_c15_side", side_light, 3'b010);
      if (c == 16) chk3("s032_c16_side", side_light, 3'b001);
      drive(1'b0, c == 3, 1'b0);
    end

    // pulse during side green is ignored; pulse on the entry edge is consumed
    reset_dut();
    for (int c = 0; c < 45; c++) begin
      to_neg();
      if (c == 40) chk3("s033_sg_hold", main_light, 3'b010);
      drive(1'b0, c == 0 || c == 10 || c == 13, 1'b0);
    end

    // pulse during side yellow: main yellow 8 cycles after re-entering main green
    reset_dut();
    for (int c = 0; c < 30; c++) begin
      to_neg();
      if (c == 26) chk3("s033_sy_c26", main_light, 3'b010);
      if (c == 27) chk3("s033_sy_c27", main_light, 3'b001);
      drive(1'b0, c == 0 || c == 17, 1'b0);
    end

    // reset in side yellow with a pending request: straight to main green, pending gone
    reset_dut();
    for (int c = 0; c < 35; c++) begin
      to_neg();
      if (c == 18) chk3("s034_c18_main", main_light, 3'b010);
      if (c == 18) chk3("s034_c18_side", side_light, 3'b100);
      if (c == 32) chk3("s034_hold", main_light, 3'b010);
      drive(c == 17, c == 0 || c == 16, 1'b0);
    end

`ifdef PED_REQ_EN
    // pedestrian pulse at cycle 0: walk during side green only
    reset_dut();
    for (int c = 0; c < 22; c++) begin
      to_neg();
      if (c == 10) chk1("s035_c10_walk", ped_walk, 1'b0);
      if (c == 11) chk1("s035_c11_walk", ped_walk, 1'b1);
      if (c == 15) chk1("s035_c15_walk", ped_walk, 1'b1);
      if (c == 16) chk1("s035_c16_walk", ped_walk, 1'b0);
      drive(1'b0, 1'b0, c == 0);
    end
`endif

    // randomized traffic with occasional resets
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      to_neg();
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
